// File: rtl/mips_datapath_alu_muldiv_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit:
// operation codes, FSM states and operation-class helpers.
package mips_datapath_alu_muldiv_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_NOP   = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MADD  = 4'd5,
    OP_MADDU = 4'd6,
    OP_MSUB  = 4'd7,
    OP_MSUBU = 4'd8,
    OP_MTHI  = 4'd9,
    OP_MTLO  = 4'd10
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } muldiv_state_e;

  function automatic logic is_iter_op(input logic [OP_W-1:0] op);
    return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
                      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
  endfunction

  function automatic logic is_div_op(input logic [OP_W-1:0] op);
    return op inside {OP_DIV, OP_DIVU};
  endfunction

  function automatic logic is_signed_op(input logic [OP_W-1:0] op);
    return op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
  endfunction

endpackage

// File: rtl/mips_datapath_alu_muldiv_step.sv
// One radix-2 iteration: shift-add for multiply (acc shifts right),
// restoring shift-subtract for divide (acc = {remainder, quotient} shifts left).
module mips_datapath_alu_muldiv_step #(
  parameter int DATA_W = 32
) (
  input  logic [2*DATA_W-1:0] i_acc,
  input  logic [DATA_W-1:0]   i_operand,
  input  logic                i_div,
  output logic [2*DATA_W-1:0] o_acc
);

  logic [DATA_W:0] w_sum;
  logic [DATA_W:0] w_diff;

  assign w_sum  = {1'b0, i_acc[2*DATA_W-1:DATA_W]} + {1'b0, i_operand};
  // Trial subtract of the left-shifted partial remainder; MSB set means it went negative.
  assign w_diff = i_acc[2*DATA_W-1:DATA_W-1] - {1'b0, i_operand};

  always_comb begin
    o_acc = i_acc;
    if (i_div) begin
      if (w_diff[DATA_W]) begin
        o_acc = {i_acc[2*DATA_W-2:0], 1'b0};
      end else begin
        o_acc = {w_diff[DATA_W-1:0], i_acc[DATA_W-2:0], 1'b1};
      end
    end else begin
      if (i_acc[0]) begin
        o_acc = {w_sum, i_acc[DATA_W-1:1]};
      end else begin
        o_acc = {1'b0, i_acc[2*DATA_W-1:1]};
      end
    end
  end

endmodule

// File: rtl/mips_datapath_alu_muldiv.sv
// Iterative multiply/divide/accumulate unit owning the architectural HI/LO
// registers; stalls the pipeline on HI/LO access while an operation is in flight.
module mips_datapath_alu_muldiv
  import mips_datapath_alu_muldiv_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [OP_W-1:0]   i_op,
  input  logic              i_start,
  input  logic              i_cancel,
  input  logic              i_hilo_access,
  input  logic [DATA_W-1:0] i_data1,
  input  logic [DATA_W-1:0] i_data2,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_stall,
  output logic [DATA_W-1:0] o_hi,
  output logic [DATA_W-1:0] o_lo
);

  muldiv_state_e       r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [OP_W-1:0]     r_op;
  logic [2*DATA_W-1:0] r_acc;
  logic [DATA_W-1:0]   r_operand;
  logic [DATA_W-1:0]   r_data1;
  logic                r_neg_q;
  logic                r_neg_r;
  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;
  logic                r_done;

  logic                w_signed_in;
  logic [DATA_W-1:0]   w_a_abs;
  logic [DATA_W-1:0]   w_b_abs;
  logic [2*DATA_W-1:0] w_step_acc;
  logic [2*DATA_W-1:0] w_prod;
  logic [2*DATA_W-1:0] w_hilo;
  logic [DATA_W-1:0]   w_quot;
  logic [DATA_W-1:0]   w_rem;

  assign w_signed_in = is_signed_op(i_op);
  assign w_a_abs = (w_signed_in && i_data1[DATA_W-1]) ? -i_data1 : i_data1;
  assign w_b_abs = (w_signed_in && i_data2[DATA_W-1]) ? -i_data2 : i_data2;

  mips_datapath_alu_muldiv_step #(.DATA_W(DATA_W)) u_step (
    .i_acc     (r_acc),
    .i_operand (r_operand),
    .i_div     (is_div_op(r_op)),
    .o_acc     (w_step_acc)
  );

  // Magnitude results are sign-corrected only once, on the commit cycle.
  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_hilo = {r_hi, r_lo};
  assign w_quot = r_neg_q ? -r_acc[DATA_W-1:0] : r_acc[DATA_W-1:0];
  assign w_rem  = r_neg_r ? -r_acc[2*DATA_W-1:DATA_W] : r_acc[2*DATA_W-1:DATA_W];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_op      <= '0;
      r_acc     <= '0;
      r_operand <= '0;
      r_data1   <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start && !i_cancel) begin
            if (i_op == OP_MTHI) begin
              r_hi <= i_data1;
            end else if (i_op == OP_MTLO) begin
              r_lo <= i_data1;
            end else if (is_iter_op(i_op)) begin
              r_state   <= ST_RUN;
              r_cnt     <= CNT_W'(DATA_W);
              r_op      <= i_op;
              r_data1   <= i_data1;
              r_neg_q   <= w_signed_in & (i_data1[DATA_W-1] ^ i_data2[DATA_W-1]);
              r_neg_r   <= w_signed_in & i_data1[DATA_W-1];
              r_acc     <= {{DATA_W{1'b0}}, is_div_op(i_op) ? w_a_abs : w_b_abs};
              r_operand <= is_div_op(i_op) ? w_b_abs : w_a_abs;
            end
          end
        end
        ST_RUN: begin
          if (i_cancel) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else begin
            r_acc <= w_step_acc;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CNT_W'(1)) begin
              r_state <= ST_FIX;
            end
          end
        end
        ST_FIX: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          if (!i_cancel) begin
            r_done <= 1'b1;
            if (is_div_op(r_op)) begin
              if (r_operand == '0) begin
                {r_hi, r_lo} <= {r_data1, {DATA_W{1'b1}}};
              end else begin
                {r_hi, r_lo} <= {w_rem, w_quot};
              end
            end else if (r_op inside {OP_MADD, OP_MADDU}) begin
              {r_hi, r_lo} <= w_hilo + w_prod;
            end else if (r_op inside {OP_MSUB, OP_MSUBU}) begin
              {r_hi, r_lo} <= w_hilo - w_prod;
            end else begin
              {r_hi, r_lo} <= w_prod;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_busy  = (r_state != ST_IDLE);
  assign o_stall = o_busy & (i_hilo_access | i_start);
  assign o_done  = r_done;
  assign o_hi    = r_hi;
  assign o_lo    = r_lo;

endmodule

// File: tb/tb_mips_datapath_alu_muldiv.sv
// Randomised and directed checks of the multiply/divide unit against an
// arithmetic reference model of HI/LO; a second 8-bit instance covers width scaling.
module tb_mips_datapath_alu_muldiv;
  import mips_datapath_alu_muldiv_pkg::*;

  localparam int W = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  op;
  logic        start, cancel, hacc;
  logic [31:0] d1, d2;
  logic        busy, done, stall;
  logic [31:0] hi, lo;

  logic [3:0]  op8;
  logic        start8;
  logic [7:0]  d1_8, d2_8;
  logic        busy8, done8, stall8;
  logic [7:0]  hi8, lo8;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  always #5 clk = ~clk;

  mips_datapath_alu_muldiv #(.DATA_W(W)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_op(op), .i_start(start), .i_cancel(cancel),
    .i_hilo_access(hacc), .i_data1(d1), .i_data2(d2), .o_busy(busy), .o_done(done),
    .o_stall(stall), .o_hi(hi), .o_lo(lo)
  );

  mips_datapath_alu_muldiv #(.DATA_W(8)) u_dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_op(op8), .i_start(start8), .i_cancel(1'b0),
    .i_hilo_access(1'b0), .i_data1(d1_8), .i_data2(d2_8), .o_busy(busy8), .o_done(done8),
    .o_stall(stall8), .o_hi(hi8), .o_lo(lo8)
  );

  // Reference: architectural effect of one operation on {HI,LO}.
  task automatic model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] hl;
    logic [63:0] up;
    longint sa, sb, q, r;
    hl = {exp_hi, exp_lo};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    up = {32'b0, a} * {32'b0, b};
    case (o)
      OP_MULT:  hl = sa * sb;
      OP_MULTU: hl = up;
      OP_MADD:  hl = hl + 64'(sa * sb);
      OP_MADDU: hl = hl + up;
      OP_MSUB:  hl = hl - 64'(sa * sb);
      OP_MSUBU: hl = hl - up;
      OP_DIV: begin
        if (b == 0) hl = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          hl = {r[31:0], q[31:0]};
        end
      end
      OP_DIVU: begin
        if (b == 0) hl = {a, 32'hFFFF_FFFF};
        else hl = {a % b, a / b};
      end
      OP_MTHI: hl[63:32] = a;
      OP_MTLO: hl[31:0] = a;
      default: ;
    endcase
    {exp_hi, exp_lo} = hl;
  endtask

  // Issues one op at the current negedge; returns at the negedge after commit.
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    int k;
    bit seen;
    op = o; d1 = a; d2 = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model(o, a, b);
    if (o == OP_MTHI || o == OP_MTLO) begin
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
        bad++;
        $display("FAIL mthilo op=%0d: busy=%b done=%b hi=%h lo=%h, want busy=0 done=0 hi=%h lo=%h",
                 o, busy, done, hi, lo, exp_hi, exp_lo);
      end
      return;
    end
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_after_start op=%0d: busy=%b want 1", o, busy);
    end
    seen = 0;
    for (k = 1; k <= W + 4; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1;
        break;
      end
    end
    total++;
    if (!seen || k != W + 1) begin
      bad++;
      $display("FAIL done_edge op=%0d: done at edge %0d (seen=%0d) want edge %0d", o, k, seen, W + 1);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL busy_at_commit op=%0d: busy=%b want 0", o, busy);
    end
    total++;
    if (hi !== exp_hi || lo !== exp_lo) begin
      bad++;
      $display("FAIL result op=%0d a=%h b=%h: hi=%h lo=%h want hi=%h lo=%h", o, a, b, hi, lo, exp_hi, exp_lo);
    end
    $display("op=%0d a=%h b=%h -> hi=%h lo=%h", o, a, b, hi, lo);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (hi !== 0 || lo !== 0 || busy !== 0 || done !== 0 || stall !== 0) begin
      bad++;
      $display("FAIL reset: hi=%h lo=%h busy=%b done=%b stall=%b want all 0", hi, lo, busy, done, stall);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 0 || done !== 0) begin
      bad++;
      $display("FAIL after_reset: busy=%b done=%b want 0", busy, done);
    end
  endtask

  task automatic test_directed();
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    total++;
    if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
      bad++;
      $display("FAIL multu_max: hi=%h lo=%h want fffffffe 00000001", hi, lo);
    end
    run_op(OP_MULT, -32'sd3, 32'd7);
    run_op(OP_MADD, 32'd2, 32'd5);
    total++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF5) begin
      bad++;
      $display("FAIL madd: hi=%h lo=%h want ffffffff fffffff5", hi, lo);
    end
    run_op(OP_DIV, -32'sd7, 32'd2);
    run_op(OP_DIVU, 32'd7, 32'd0);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    total++;
    if (hi !== 32'h0 || lo !== 32'h8000_0000) begin
      bad++;
      $display("FAIL div_overflow: hi=%h lo=%h want 00000000 80000000", hi, lo);
    end
    run_op(OP_MTHI, 32'h1234, 32'h0);
    run_op(OP_MSUBU, 32'h0001_0000, 32'h0001_0000);
    run_op(OP_DIV, 32'd9, -32'sd4);
  endtask

  task automatic test_random();
    logic [3:0] ops [8];
    logic [31:0] a, b;
    int sel;
    ops = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) b = 32'h0;
      else if (sel == 1) b = $urandom_range(1, 15);
      else if (sel == 2) b = -$urandom_range(1, 15);
      run_op(ops[$urandom_range(0, 7)], a, b);
    end
  endtask

  task automatic test_stall();
    hacc = 1'b1;
    op = OP_MULTU; d1 = 32'd12345; d2 = 32'd678; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model(OP_MULTU, 32'd12345, 32'd678);
    for (int k = 0; k <= W + 1; k++) begin
      if (k > 0) @(negedge clk);
      total++;
      if (stall !== (k <= W)) begin
        bad++;
        $display("FAIL stall k=%0d: stall=%b want %b", k, stall, (k <= W));
      end
    end
    hacc = 1'b0;
    total++;
    if (hi !== exp_hi || lo !== exp_lo || done !== 1'b1) begin
      bad++;
      $display("FAIL stall_result: hi=%h lo=%h done=%b want %h %h done=1", hi, lo, done, exp_hi, exp_lo);
    end
    $display("stall window checked, hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_cancel();
    int dones;
    run_op(OP_MTHI, 32'hAAAA_5555, 32'h0);
    run_op(OP_MTLO, 32'h1357_9BDF, 32'h0);
    op = OP_MULT; d1 = 32'd100; d2 = 32'd200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL cancel_busy: busy=%b want 0", busy);
    end
    dones = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    total++;
    if (dones != 0 || hi !== exp_hi || lo !== exp_lo) begin
      bad++;
      $display("FAIL cancel_result: dones=%0d hi=%h lo=%h want 0 %h %h", dones, hi, lo, exp_hi, exp_lo);
    end
    op = OP_MTHI; d1 = 32'hDEAD_BEEF; start = 1'b1; cancel = 1'b1;
    @(negedge clk);
    op = OP_MULTU;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    total++;
    if (busy !== 1'b0 || hi !== exp_hi) begin
      bad++;
      $display("FAIL cancel_start_idle: busy=%b hi=%h want 0 %h", busy, hi, exp_hi);
    end
    $display("cancel checked, hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_reset_mid();
    op = OP_DIVU; d1 = 32'd1000; d2 = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (hi !== 0 || lo !== 0 || busy !== 0 || done !== 0) begin
      bad++;
      $display("FAIL reset_mid: hi=%h lo=%h busy=%b done=%b want all 0", hi, lo, busy, done);
    end
    exp_hi = '0;
    exp_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset mid-op checked");
  endtask

  task automatic test_w8_op(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] want_hi, input logic [7:0] want_lo);
    int k;
    bit seen;
    op8 = o; d1_8 = a; d2_8 = b; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    seen = 0;
    for (k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (done8 === 1'b1) begin
        seen = 1;
        break;
      end
    end
    total++;
    if (!seen || k != 9 || hi8 !== want_hi || lo8 !== want_lo) begin
      bad++;
      $display("FAIL w8 op=%0d: edge=%0d hi=%h lo=%h want edge 9 hi=%h lo=%h", o, k, hi8, lo8, want_hi, want_lo);
    end
    $display("w8 op=%0d a=%h b=%h -> hi=%h lo=%h", o, a, b, hi8, lo8);
  endtask

  initial begin
    op = OP_NOP; start = 0; cancel = 0; hacc = 0; d1 = 0; d2 = 0;
    op8 = OP_NOP; start8 = 0; d1_8 = 0; d2_8 = 0;
    test_reset();
    test_directed();
    test_random();
    test_stall();
    test_cancel();
    test_reset_mid();
    test_w8_op(OP_MULTU, 8'd200, 8'd200, 8'h9C, 8'h40);
    test_w8_op(OP_DIV, 8'hF9, 8'd2, 8'hFF, 8'hFD);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
